// File: rtl/rs544_encoder_fwd.sv
// Systematic RS(544,522) encoder over GF(2^10), x^10+x^3+1, 32 symbols per beat.
// The parity LFSR is unrolled across a whole beat; every accepted beat leaves one cycle later.
module rs544_encoder_fwd #(
    parameter int M     = 32,
    parameter int NPAR  = 22,
    parameter int NBEAT = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              last_i,
    input  logic [M-1:0][9:0] data_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [M-1:0][9:0] data_o,
    output logic              busy_o,
    output logic              frame_err_o
);
    localparam int         NMSG_LAST = M - NPAR;
    localparam logic [4:0] LAST_CNT  = 5'(NBEAT - 1);

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        logic [9:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[8:0], 1'b0} ^ (x[9] ? 10'h009 : 10'h000);
        end
        return p;
    endfunction

    // g(x) = prod (x + a^j), j = 1..NPAR; returns g_0..g_{NPAR-1} (g_NPAR = 1 implied)
    function automatic logic [NPAR*10-1:0] calc_gen();
        logic [(NPAR+1)*10-1:0] g;
        logic [9:0]             aj;
        g       = '0;
        g[9:0]  = 10'd1;
        aj      = 10'd1;
        for (int j = 1; j <= NPAR; j++) begin
            aj = gf_mul(aj, 10'h002);
            for (int i = NPAR; i >= 1; i--)
                g[i*10 +: 10] = g[(i-1)*10 +: 10] ^ gf_mul(aj, g[i*10 +: 10]);
            g[9:0] = gf_mul(aj, g[9:0]);
        end
        return g[NPAR*10-1:0];
    endfunction

    localparam logic [NPAR*10-1:0] GEN = calc_gen();

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic [NPAR-1:0][9:0] r_par;

    logic [NPAR-1:0][9:0] w_lfsr;
    logic [9:0]           w_fb;
    logic [NPAR-1:0][9:0] w_par_full;
    logic [NPAR-1:0][9:0] w_par_last;

    // Symbols are consumed highest index first; the last-beat parity is tapped after the 10 message symbols.
    always_comb begin
        w_lfsr     = start_i ? '0 : r_par;
        w_fb       = '0;
        w_par_last = '0;
        for (int s = 0; s < M; s++) begin
            w_fb = data_i[M-1-s] ^ w_lfsr[NPAR-1];
            for (int i = NPAR-1; i >= 1; i--)
                w_lfsr[i] = w_lfsr[i-1] ^ gf_mul(GEN[i*10 +: 10], w_fb);
            w_lfsr[0] = gf_mul(GEN[9:0], w_fb);
            if (s == NMSG_LAST-1) w_par_last = w_lfsr;
        end
        w_par_full = w_lfsr;
    end

    assign busy_o = (r_state == S_BUSY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_par       <= '0;
            valid_o     <= 1'b0;
            start_o     <= 1'b0;
            last_o      <= 1'b0;
            data_o      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            start_o     <= 1'b0;
            last_o      <= 1'b0;
            frame_err_o <= 1'b0;
            if (valid_i) begin
                if (start_i && last_i) begin
                    frame_err_o <= 1'b1;
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                end else if (start_i) begin
                    // a start while busy aborts the old frame and restarts cleanly
                    frame_err_o <= (r_state == S_BUSY);
                    valid_o     <= 1'b1;
                    start_o     <= 1'b1;
                    data_o      <= data_i;
                    r_par       <= w_par_full;
                    r_cnt       <= 5'd1;
                    r_state     <= S_BUSY;
                end else if (r_state == S_IDLE) begin
                    frame_err_o <= 1'b1;
                end else begin
                    valid_o <= 1'b1;
                    data_o  <= data_i;
                    if (last_i || (r_cnt == LAST_CNT)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        if (last_i && (r_cnt == LAST_CNT)) begin
                            last_o <= 1'b1;
                            data_o <= {data_i[M-1:NPAR], w_par_last};
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                        r_par <= w_par_full;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rs544_encoder_fwd.sv
// Directed bench for rs544_encoder_fwd: codewords are checked by evaluating all 22 syndromes,
// parity of a unit message against an independently built generator polynomial.
module tb_rs544_encoder_fwd;
    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             start_i;
    logic             last_i;
    logic [31:0][9:0] data_i;
    logic             valid_o;
    logic             start_o;
    logic             last_o;
    logic [31:0][9:0] data_o;
    logic             busy_o;
    logic             frame_err_o;

    rs544_encoder_fwd dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .start_i    (start_i),
        .last_i     (last_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .start_o    (start_o),
        .last_o     (last_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic             ov, os, ol, oe, ob;
    logic [31:0][9:0] od;
    logic [31:0][9:0] tx_msg [0:16];
    logic [31:0][9:0] rx_cw  [0:16];
    logic [9:0]       gb     [0:22];
    int               vmis;
    int               errseen;

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        logic [9:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[8:0], 1'b0} ^ (x[9] ? 10'h009 : 10'h000);
        end
        return p;
    endfunction

    function automatic logic [31:0][9:0] rand_beat();
        logic [31:0][9:0] r;
        for (int m = 0; m < 32; m++) r[m] = 10'($urandom_range(0, 1023));
        return r;
    endfunction

    // number of nonzero syndromes S_j = c(a^j) of the captured codeword
    function automatic int syn_nonzero();
        int         cnt;
        logic [9:0] aj;
        logic [9:0] s;
        cnt = 0;
        aj  = 10'd1;
        for (int j = 1; j <= 22; j++) begin
            aj = gf_mul(aj, 10'h002);
            s  = '0;
            for (int k = 0; k < 17; k++)
                for (int m = 31; m >= 0; m--)
                    s = gf_mul(s, aj) ^ rx_cw[k][m];
            if (s != 10'd0) cnt++;
        end
        return cnt;
    endfunction

    function automatic int sys_mismatch();
        int cnt;
        cnt = 0;
        for (int k = 0; k < 16; k++)
            if (rx_cw[k] !== tx_msg[k]) cnt++;
        if (rx_cw[16][31:22] !== tx_msg[16][31:22]) cnt++;
        return cnt;
    endfunction

    task automatic build_gen();
        logic [9:0] aj;
        for (int i = 0; i <= 22; i++) gb[i] = '0;
        gb[0] = 10'd1;
        aj    = 10'd1;
        for (int j = 1; j <= 22; j++) begin
            aj = gf_mul(aj, 10'h002);
            for (int i = 22; i >= 1; i--) gb[i] = gb[i-1] ^ gf_mul(aj, gb[i]);
            gb[0] = gf_mul(aj, gb[0]);
        end
    endtask

    task automatic rand_msg();
        for (int k = 0; k < 17; k++) tx_msg[k] = rand_beat();
    endtask

    task automatic step(input logic v, input logic s, input logic l, input logic [31:0][9:0] d);
        @(negedge clk_i);
        valid_i = v;
        start_i = s;
        last_i  = l;
        data_i  = d;
        @(posedge clk_i);
        #1;
        ov = valid_o;
        os = start_o;
        ol = last_o;
        oe = frame_err_o;
        ob = busy_o;
        od = data_o;
    endtask

    // sends tx_msg as one frame; tallies protocol deviations into vmis / errseen
    task automatic send_frame(input int maxgap, input logic first_err);
        int gap;
        vmis    = 0;
        errseen = 0;
        for (int k = 0; k < 17; k++) begin
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_beat());
                if (ov !== 1'b0 || oe !== 1'b0 || ob !== (k != 0 || first_err)) vmis++;
            end
            step(1'b1, k == 0, k == 16, tx_msg[k]);
            if (ov !== 1'b1 || os !== (k == 0) || ol !== (k == 16) || ob !== (k != 16)) vmis++;
            if (oe !== ((k == 0) && first_err)) errseen++;
            rx_cw[k] = od;
        end
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        start_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({valid_o, start_o, last_o, busy_o, frame_err_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000", {valid_o, start_o, last_o, busy_o, frame_err_o});
        end
        n_cmp++;
        if (data_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_zero_frame();
        int nz;
        for (int k = 0; k < 17; k++) tx_msg[k] = '0;
        send_frame(0, 1'b0);
        n_cmp++;
        if (vmis !== 0) begin n_err++; $display("FAIL zero_framing: got %0d bad beats want 0", vmis); end
        n_cmp++;
        if (errseen !== 0) begin n_err++; $display("FAIL zero_frame_err: got %0d want 0", errseen); end
        nz = 0;
        for (int k = 0; k < 17; k++) if (rx_cw[k] !== '0) nz++;
        n_cmp++;
        if (nz !== 0) begin n_err++; $display("FAIL zero_data: got %0d nonzero beats want 0", nz); end
    endtask

    task automatic test_gen_poly();
        logic [9:0] a253;
        logic [9:0] asum;
        logic [9:0] aj;
        for (int k = 0; k < 17; k++) tx_msg[k] = '0;
        tx_msg[16][22] = 10'd1;
        send_frame(0, 1'b0);
        n_cmp++;
        if (vmis !== 0) begin n_err++; $display("FAIL gen_framing: got %0d want 0", vmis); end
        for (int i = 0; i < 22; i++) begin
            n_cmp++;
            if (rx_cw[16][i] !== gb[i]) begin
                n_err++;
                $display("FAIL gen_coef_%0d: got %h want %h", i, rx_cw[16][i], gb[i]);
            end
        end
        // g_0 = a^(1+..+22) = a^253, g_21 = sum of the roots
        a253 = 10'd1;
        for (int i = 0; i < 253; i++) a253 = gf_mul(a253, 10'h002);
        asum = '0;
        aj   = 10'd1;
        for (int j = 1; j <= 22; j++) begin
            aj   = gf_mul(aj, 10'h002);
            asum = asum ^ aj;
        end
        n_cmp++;
        if (rx_cw[16][0] !== a253) begin n_err++; $display("FAIL gen_g0: got %h want %h", rx_cw[16][0], a253); end
        n_cmp++;
        if (rx_cw[16][21] !== asum) begin n_err++; $display("FAIL gen_g21: got %h want %h", rx_cw[16][21], asum); end
        n_cmp++;
        if (rx_cw[16][31:22] !== tx_msg[16][31:22]) begin
            n_err++;
            $display("FAIL gen_msg: got %h want %h", rx_cw[16][31:22], tx_msg[16][31:22]);
        end
    endtask

    task automatic test_back_to_back();
        int sn;
        int sm;
        for (int f = 0; f < 3; f++) begin
            rand_msg();
            send_frame(0, 1'b0);
            sn = syn_nonzero();
            sm = sys_mismatch();
            n_cmp++;
            if (vmis !== 0) begin n_err++; $display("FAIL b2b_framing_%0d: got %0d want 0", f, vmis); end
            n_cmp++;
            if (errseen !== 0) begin n_err++; $display("FAIL b2b_err_%0d: got %0d want 0", f, errseen); end
            n_cmp++;
            if (sn !== 0) begin n_err++; $display("FAIL b2b_syndromes_%0d: got %0d nonzero want 0", f, sn); end
            n_cmp++;
            if (sm !== 0) begin n_err++; $display("FAIL b2b_systematic_%0d: got %0d want 0", f, sm); end
        end
    endtask

    task automatic test_gaps();
        logic [31:0][9:0] p0;
        int               sn;
        rand_msg();
        send_frame(0, 1'b0);
        p0 = rx_cw[16];
        send_frame(5, 1'b0);
        sn = syn_nonzero();
        n_cmp++;
        if (rx_cw[16] !== p0) begin n_err++; $display("FAIL gap_parity: got %h want %h", rx_cw[16], p0); end
        n_cmp++;
        if (vmis !== 0) begin n_err++; $display("FAIL gap_valid: got %0d bad cycles want 0", vmis); end
        n_cmp++;
        if (errseen !== 0) begin n_err++; $display("FAIL gap_err: got %0d want 0", errseen); end
        n_cmp++;
        if (sn !== 0) begin n_err++; $display("FAIL gap_syndromes: got %0d want 0", sn); end
    endtask

    task automatic test_early_last();
        int sn;
        rand_msg();
        step(1'b1, 1'b1, 1'b0, tx_msg[0]);
        for (int k = 1; k < 10; k++) step(1'b1, 1'b0, 1'b0, tx_msg[k]);
        step(1'b1, 1'b0, 1'b1, tx_msg[10]);
        n_cmp++;
        if ({oe, ov, ol, ob} !== 4'b1100) begin
            n_err++;
            $display("FAIL early_last_flags: got err/valid/last/busy=%b want 1100", {oe, ov, ol, ob});
        end
        n_cmp++;
        if (od !== tx_msg[10]) begin n_err++; $display("FAIL early_last_data: got %h want %h", od, tx_msg[10]); end
        step(1'b0, 1'b0, 1'b0, '0);
        n_cmp++;
        if (oe !== 1'b0) begin n_err++; $display("FAIL early_last_pulse: got %b want 0", oe); end
        rand_msg();
        send_frame(0, 1'b0);
        sn = syn_nonzero();
        n_cmp++;
        if (sn !== 0 || vmis !== 0 || errseen !== 0) begin
            n_err++;
            $display("FAIL early_last_next: got syn=%0d framing=%0d err=%0d want 0/0/0", sn, vmis, errseen);
        end
    endtask

    task automatic test_overrun();
        rand_msg();
        step(1'b1, 1'b1, 1'b0, tx_msg[0]);
        for (int k = 1; k < 16; k++) step(1'b1, 1'b0, 1'b0, tx_msg[k]);
        step(1'b1, 1'b0, 1'b0, tx_msg[16]);
        n_cmp++;
        if ({oe, ov, ol, ob} !== 4'b1100) begin
            n_err++;
            $display("FAIL overrun_flags: got err/valid/last/busy=%b want 1100", {oe, ov, ol, ob});
        end
        step(1'b1, 1'b0, 1'b0, rand_beat());
        n_cmp++;
        if ({oe, ov, ob} !== 3'b100) begin
            n_err++;
            $display("FAIL idle_beat_drop: got err/valid/busy=%b want 100", {oe, ov, ob});
        end
    endtask

    task automatic test_restart_and_reset();
        int sn;
        rand_msg();
        for (int k = 0; k < 7; k++) step(1'b1, k == 0, 1'b0, tx_msg[k]);
        rand_msg();
        send_frame(0, 1'b1);
        sn = syn_nonzero();
        n_cmp++;
        if (errseen !== 0) begin n_err++; $display("FAIL restart_err_pulse: got %0d wrong beats want 0", errseen); end
        n_cmp++;
        if (sn !== 0 || vmis !== 0) begin
            n_err++;
            $display("FAIL restart_encode: got syn=%0d framing=%0d want 0/0", sn, vmis);
        end
        step(1'b1, 1'b1, 1'b1, rand_beat());
        n_cmp++;
        if ({oe, ov, ob} !== 3'b100) begin
            n_err++;
            $display("FAIL start_last_idle: got err/valid/busy=%b want 100", {oe, ov, ob});
        end
        step(1'b1, 1'b1, 1'b0, rand_beat());
        step(1'b1, 1'b1, 1'b1, rand_beat());
        n_cmp++;
        if ({oe, ov, ob} !== 3'b100) begin
            n_err++;
            $display("FAIL start_last_busy: got err/valid/busy=%b want 100", {oe, ov, ob});
        end
        rand_msg();
        for (int k = 0; k < 9; k++) step(1'b1, k == 0, 1'b0, tx_msg[k]);
        @(negedge clk_i);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({valid_o, start_o, busy_o, frame_err_o} !== 4'b0 || data_o !== '0) begin
            n_err++;
            $display("FAIL midframe_reset: got valid/start/busy/err=%b data=%h want 0000 / 0",
                     {valid_o, start_o, busy_o, frame_err_o}, data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        rand_msg();
        send_frame(2, 1'b0);
        sn = syn_nonzero();
        n_cmp++;
        if (sn !== 0 || vmis !== 0 || errseen !== 0) begin
            n_err++;
            $display("FAIL post_reset_encode: got syn=%0d framing=%0d err=%0d want 0/0/0", sn, vmis, errseen);
        end
    endtask

    initial begin
        build_gen();
        test_reset();
        test_zero_frame();
        test_gen_poly();
        test_back_to_back();
        test_gaps();
        test_early_last();
        test_overrun();
        test_restart_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
